// File: rtl/ysyx_24110006_pkg.sv
// Shared constants and types for the decode queue: RISC-V opcode classes,
// trap cause codes, special instruction encodings and the queued entry layout.
package ysyx_24110006_pkg;

  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;

  localparam logic [3:0] MCAUSE_NONE       = 4'd0;
  localparam logic [3:0] MCAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] MCAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] MCAUSE_ECALL_M    = 4'd11;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        exception;
    logic [3:0]  mcause;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_24110006_sync_fifo.sv
// Circular-buffer storage for the decode queue: head data is read
// combinationally, flush clears pointers and count in one cycle.
module ysyx_24110006_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately left unreset; validity is tracked by o_count.
  always_ff @(posedge i_clock) begin
    if (i_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  assign o_data = mem[rd_ptr];

endmodule

// File: rtl/ysyx_24110006_decode_queue.sv
// Fetch-to-decode queue with combinational decode of the head entry.
// Define YSYX_24110006_RVE_EN to flag register indices >= 16 as illegal.
module ysyx_24110006_decode_queue
  import ysyx_24110006_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [31:0]            i_inst,
  input  logic [31:0]            i_pc,
  input  logic [31:0]            i_imm,
  input  logic                   i_exception,
  input  logic [3:0]             i_mcause,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic                   i_flush,
  input  logic                   i_stall,
  output logic [6:0]             o_op,
  output logic [2:0]             o_func,
  output logic [4:0]             o_reg_rs1,
  output logic [4:0]             o_reg_rs2,
  output logic [4:0]             o_reg_rd,
  output logic                   o_reg_wen,
  output logic [31:0]            o_imm,
  output logic [31:0]            o_pc,
  output logic [11:0]            o_csr,
  output logic [1:0]             o_csr_t,
  output logic                   o_mret,
  output logic                   o_exception,
  output logic [3:0]             o_mcause,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int                CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);

  fetch_entry_t in_entry;
  fetch_entry_t head;
  logic         push;
  logic         pop;

  // Ready comes only from the registered count, so a full queue never
  // accepts a push even if it is being drained in the same cycle.
  assign o_ready = (o_count != FULL);
  assign o_valid = (o_count != '0);
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready && !i_stall && !i_flush;

  assign in_entry = '{inst: i_inst, pc: i_pc, imm: i_imm,
                      exception: i_exception, mcause: i_mcause};

  ysyx_24110006_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (in_entry),
    .o_data  (head),
    .o_count (o_count)
  );

  logic [4:0] cls;
  logic       known;
  logic       writes_rd;
  logic       is_system;
  logic       illegal;
  logic       local_exc;
  logic [3:0] local_cause;
`ifdef YSYX_24110006_RVE_EN
  logic       uses_rd;
  logic       uses_rs1;
  logic       uses_rs2;
`endif

  // Everything is gated by o_valid so an empty queue never reports a trap.
  always_comb begin
    cls         = head.inst[6:2];
    known       = 1'b0;
    writes_rd   = 1'b0;
    is_system   = 1'b0;
    illegal     = 1'b0;
    local_exc   = 1'b0;
    local_cause = MCAUSE_NONE;
`ifdef YSYX_24110006_RVE_EN
    uses_rd     = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
`endif
    o_op        = '0;
    o_func      = '0;
    o_reg_rs1   = '0;
    o_reg_rs2   = '0;
    o_reg_rd    = '0;
    o_reg_wen   = 1'b0;
    o_imm       = '0;
    o_pc        = '0;
    o_csr       = '0;
    o_csr_t     = '0;
    o_mret      = 1'b0;
    o_exception = 1'b0;
    o_mcause    = '0;

    if (o_valid) begin
      o_op      = head.inst[6:0];
      o_func    = head.inst[14:12];
      o_reg_rd  = head.inst[11:7];
      o_reg_rs1 = head.inst[19:15];
      o_reg_rs2 = head.inst[24:20];
      o_csr     = head.inst[31:20];
      o_imm     = head.imm;
      o_pc      = head.pc;

      case (cls)
        OPC_OP_IMM, OPC_OP, OPC_LOAD, OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI: begin
          known     = 1'b1;
          writes_rd = 1'b1;
        end
        OPC_STORE, OPC_BRANCH, OPC_MISC_MEM: known = 1'b1;
        OPC_SYSTEM: begin
          known     = 1'b1;
          is_system = 1'b1;
        end
        default: known = 1'b0;
      endcase

      o_mret     = (head.inst == INST_MRET);
      o_csr_t[0] = is_system && (o_func != 3'd0);
      o_csr_t[1] = o_mret;

      illegal = !known;
`ifdef YSYX_24110006_RVE_EN
      uses_rd  = writes_rd || o_csr_t[0];
      uses_rs1 = (cls == OPC_OP_IMM) || (cls == OPC_OP) || (cls == OPC_LOAD) ||
                 (cls == OPC_STORE) || (cls == OPC_JALR) || (cls == OPC_BRANCH) ||
                 (o_csr_t[0] && !o_func[2]);
      uses_rs2 = (cls == OPC_OP) || (cls == OPC_STORE) || (cls == OPC_BRANCH);
      if ((uses_rd && o_reg_rd[4]) || (uses_rs1 && o_reg_rs1[4]) ||
          (uses_rs2 && o_reg_rs2[4]))
        illegal = 1'b1;
`endif

      if (illegal) begin
        local_exc   = 1'b1;
        local_cause = MCAUSE_ILLEGAL;
      end else if (head.inst == INST_EBREAK) begin
        local_exc   = 1'b1;
        local_cause = MCAUSE_BREAKPOINT;
      end else if (head.inst == INST_ECALL) begin
        local_exc   = 1'b1;
        local_cause = MCAUSE_ECALL_M;
      end

      o_exception = head.exception || local_exc;
      o_mcause    = head.exception ? head.mcause : local_cause;
      o_reg_wen   = writes_rd && !o_exception;
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_decode_queue.sv
// Directed self-checking bench for ysyx_24110006_decode_queue (DEPTH=4).
module tb_ysyx_24110006_decode_queue;

  logic        i_clock;
  logic        i_reset;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] i_imm;
  logic        i_exception;
  logic [3:0]  i_mcause;
  logic        i_valid;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic        i_flush;
  logic        i_stall;
  logic [6:0]  o_op;
  logic [2:0]  o_func;
  logic [4:0]  o_reg_rs1;
  logic [4:0]  o_reg_rs2;
  logic [4:0]  o_reg_rd;
  logic        o_reg_wen;
  logic [31:0] o_imm;
  logic [31:0] o_pc;
  logic [11:0] o_csr;
  logic [1:0]  o_csr_t;
  logic        o_mret;
  logic        o_exception;
  logic [3:0]  o_mcause;
  logic [2:0]  o_count;

  int tests_run;
  int tests_failed;
  int exp_count;

  ysyx_24110006_decode_queue #(.DEPTH(4)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_inst      (i_inst),
    .i_pc        (i_pc),
    .i_imm       (i_imm),
    .i_exception (i_exception),
    .i_mcause    (i_mcause),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .i_flush     (i_flush),
    .i_stall     (i_stall),
    .o_op        (o_op),
    .o_func      (o_func),
    .o_reg_rs1   (o_reg_rs1),
    .o_reg_rs2   (o_reg_rs2),
    .o_reg_rd    (o_reg_rd),
    .o_reg_wen   (o_reg_wen),
    .o_imm       (o_imm),
    .o_pc        (o_pc),
    .o_csr       (o_csr),
    .o_csr_t     (o_csr_t),
    .o_mret      (o_mret),
    .o_exception (o_exception),
    .o_mcause    (o_mcause),
    .o_count     (o_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] imm, input logic exc,
                               input logic [3:0] cause);
    i_inst      = inst;
    i_pc        = pc;
    i_imm       = imm;
    i_exception = exc;
    i_mcause    = cause;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_flush  = 1'b0;
    i_stall  = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    #1;
    checkOutput("reset_count", 32'(o_count), 32'd0);
    checkOutput("reset_ready", 32'(o_ready), 32'd1);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_exception", 32'(o_exception), 32'd0);
    checkOutput("reset_op", 32'(o_op), 32'd0);
    tick();
    i_reset = 1'b0;
    tick();

    // Fill the queue with downstream blocked, then offer a fifth entry.
    i_valid = 1'b1;
    applyStimulus(32'h0050_0093, 32'h8000_0000, 32'd5, 1'b0, 4'd0);
    tick();
    checkOutput("latency_valid", 32'(o_valid), 32'd1);
    checkOutput("addi_op", 32'(o_op), 32'h13);
    checkOutput("addi_rd", 32'(o_reg_rd), 32'd1);
    checkOutput("addi_wen", 32'(o_reg_wen), 32'd1);
    checkOutput("addi_imm", o_imm, 32'd5);
    applyStimulus(32'h0020_81B3, 32'h8000_0004, 32'd0, 1'b0, 4'd0);
    tick();
    applyStimulus(32'h0020_A023, 32'h8000_0008, 32'd0, 1'b0, 4'd0);
    tick();
    applyStimulus(32'h1234_52B7, 32'h8000_000C, 32'h1234_5000, 1'b0, 4'd0);
    tick();
    checkOutput("full_count", 32'(o_count), 32'd4);
    checkOutput("full_ready", 32'(o_ready), 32'd0);
    applyStimulus(32'hDEAD_BEEF, 32'h8000_0010, 32'd0, 1'b0, 4'd0);
    tick();
    checkOutput("fifth_ignored_count", 32'(o_count), 32'd4);
    checkOutput("head_pc_kept", o_pc, 32'h8000_0000);

    // Full plus both handshakes: one pop, no push.
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    checkOutput("full_pop_count", 32'(o_count), 32'd3);
    checkOutput("full_pop_ready", 32'(o_ready), 32'd1);
    checkOutput("add_op", 32'(o_op), 32'h33);
    checkOutput("add_rs1", 32'(o_reg_rs1), 32'd1);
    checkOutput("add_rs2", 32'(o_reg_rs2), 32'd2);
    checkOutput("add_rd", 32'(o_reg_rd), 32'd3);
    tick();
    checkOutput("sw_func", 32'(o_func), 32'd2);
    checkOutput("sw_wen", 32'(o_reg_wen), 32'd0);
    checkOutput("sw_exception", 32'(o_exception), 32'd0);
    tick();
    checkOutput("lui_rd", 32'(o_reg_rd), 32'd5);
    checkOutput("lui_pc", o_pc, 32'h8000_000C);
    tick();
    checkOutput("drained_valid", 32'(o_valid), 32'd0);
    checkOutput("drained_op", 32'(o_op), 32'd0);
    i_ready = 1'b0;

    // ecall.
    i_valid = 1'b1;
    applyStimulus(32'h0000_0073, 32'h8000_0000, 32'd0, 1'b0, 4'd0);
    tick();
    i_valid = 1'b0;
    checkOutput("ecall_valid", 32'(o_valid), 32'd1);
    checkOutput("ecall_exception", 32'(o_exception), 32'd1);
    checkOutput("ecall_mcause", 32'(o_mcause), 32'd11);
    checkOutput("ecall_wen", 32'(o_reg_wen), 32'd0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // Upstream fault overrides the local illegal cause.
    i_valid = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0020, 32'd0, 1'b1, 4'd1);
    tick();
    i_valid = 1'b0;
    checkOutput("upstream_exception", 32'(o_exception), 32'd1);
    checkOutput("upstream_mcause", 32'(o_mcause), 32'd1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // Illegal, ebreak, mret, csrrw queued back to back.
    i_valid = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0030, 32'd0, 1'b0, 4'd0);
    tick();
    applyStimulus(32'h0010_0073, 32'h8000_0034, 32'd0, 1'b0, 4'd0);
    tick();
    applyStimulus(32'h3020_0073, 32'h8000_0038, 32'd0, 1'b0, 4'd0);
    tick();
    applyStimulus(32'h3001_10F3, 32'h8000_003C, 32'd0, 1'b0, 4'd0);
    tick();
    i_valid = 1'b0;
    checkOutput("illegal_mcause", 32'(o_mcause), 32'd2);
    checkOutput("illegal_exception", 32'(o_exception), 32'd1);
    i_ready = 1'b1;
    tick();
    checkOutput("ebreak_mcause", 32'(o_mcause), 32'd3);
    tick();
    checkOutput("mret_flag", 32'(o_mret), 32'd1);
    checkOutput("mret_csr_t", 32'(o_csr_t), 32'd2);
    checkOutput("mret_exception", 32'(o_exception), 32'd0);
    tick();
    checkOutput("csrrw_csr_t", 32'(o_csr_t), 32'd1);
    checkOutput("csrrw_csr", 32'(o_csr), 32'h300);
    checkOutput("csrrw_wen", 32'(o_reg_wen), 32'd0);
    checkOutput("csrrw_mret", 32'(o_mret), 32'd0);
    tick();
    checkOutput("empty_again", 32'(o_count), 32'd0);
    i_ready = 1'b0;

    // Flush beats a simultaneous push and pop.
    i_valid = 1'b1;
    applyStimulus(32'h0050_0093, 32'h8000_0040, 32'd5, 1'b0, 4'd0);
    tick();
    tick();
    tick();
    checkOutput("preflush_count", 32'(o_count), 32'd3);
    i_flush = 1'b1;
    i_ready = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    checkOutput("flush_count", 32'(o_count), 32'd0);
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("flush_ready", 32'(o_ready), 32'd1);
    tick();
    checkOutput("flush_push_dropped", 32'(o_count), 32'd0);

    // Stall holds the head while pushes keep filling the queue.
    i_valid = 1'b1;
    applyStimulus(32'h0050_0093, 32'h8000_0050, 32'd5, 1'b0, 4'd0);
    tick();
    i_stall = 1'b1;
    i_ready = 1'b1;
    applyStimulus(32'h0020_81B3, 32'h8000_0054, 32'd0, 1'b0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_count = (k + 1 > 4) ? 4 : k + 1;
      checkOutput("stall_count", 32'(o_count), 32'(exp_count));
      checkOutput("stall_op", 32'(o_op), 32'h13);
      checkOutput("stall_pc", o_pc, 32'h8000_0050);
    end
    i_valid = 1'b0;
    i_stall = 1'b0;
    tick();
    i_ready = 1'b0;
    checkOutput("unstall_count", 32'(o_count), 32'd3);
    checkOutput("unstall_op", 32'(o_op), 32'h33);

    // Asynchronous reset while occupied, between clock edges.
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("async_reset_count", 32'(o_count), 32'd0);
    checkOutput("async_reset_valid", 32'(o_valid), 32'd0);
    checkOutput("async_reset_op", 32'(o_op), 32'd0);
    tick();
    i_reset = 1'b0;
    tick();
    checkOutput("post_reset_count", 32'(o_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
